rijndael_subbytes_engine: RTL and testbench

- Parametrised SubBytes / InvSubBytes engine for a Rijndael state of NUM_LANES bytes (Rijndael block sizes 128–256 bits).
- Time-multiplexes NUM_SBOX byte substitution instances over the state, trading latency for area.
- Valid/ready handshake on both sides. Sits between the round-key-add and ShiftRows stages of the round datapath.
- Adds an inverse (decryption) mode per transaction.

---
 rtl/rijndael_pkg.sv | 62 ++++++
 rtl/rijndael_subbytes_engine_if.sv | 25 ++
 rtl/rijndael_sbox_dual.sv | 13 +
 rtl/rijndael_subbytes_engine.sv | 127 ++++++++++++
 tb/tb_rijndael_subbytes_engine.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rijndael_pkg.sv
// Shared types, S-box constants and parameter helpers for the SubBytes engine.
package rijndael_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Number of substitution passes needed to cover the whole state.
    function automatic int unsigned chunk_count(input int unsigned lanes, input int unsigned sbox);
        return lanes / sbox;
    endfunction

    // Legal Rijndael state widths with an S-box count that tiles them exactly.
    function automatic bit params_legal(input int unsigned lanes, input int unsigned sbox);
        bit lanes_ok;
        lanes_ok = (lanes == 16) || (lanes == 20) || (lanes == 24) || (lanes == 28) || (lanes == 32);
        return lanes_ok && (sbox >= 1) && (sbox <= lanes) && ((lanes % sbox) == 0);
    endfunction

endpackage

// File: rtl/rijndael_subbytes_engine_if.sv
// Valid/ready handshake bundle between the state producer, the engine and the consumer.
interface rijndael_subbytes_engine_if #(
    parameter int unsigned NUM_LANES = 16
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic                     in_inv_i;
    logic [8*NUM_LANES-1:0]   in_data_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [8*NUM_LANES-1:0]   out_data_o;
    logic                     busy_o;

    // Environment side: drives input states and consumer ready.
    modport master (
        output in_valid_i, in_inv_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    // Engine side.
    modport slave (
        input  in_valid_i, in_inv_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
endinterface

// File: rtl/rijndael_sbox_dual.sv
// Single-byte forward/inverse Rijndael substitution.
module rijndael_sbox_dual
    import rijndael_pkg::*;
(
    input  byte_t x_i,
    input  logic  inv_i,
    output byte_t y_o
);
    // Table lookup selected by direction.
    always_comb begin
        y_o = inv_i ? SBOX_INV[x_i] : SBOX_FWD[x_i];
    end
endmodule

// File: rtl/rijndael_subbytes_engine.sv
// SubBytes / InvSubBytes engine sweeping NUM_SBOX substitution units over the state.
module rijndael_subbytes_engine
    import rijndael_pkg::*;
#(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned NUM_SBOX  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    rijndael_subbytes_engine_if.slave   bus
);
    localparam int unsigned C  = chunk_count(NUM_LANES, NUM_SBOX);
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned DW = 8 * NUM_LANES;
    localparam int unsigned KW = 8 * NUM_SBOX;

    if (!params_legal(NUM_LANES, NUM_SBOX)) begin : g_bad_params
        $error("rijndael_subbytes_engine: illegal NUM_LANES/NUM_SBOX combination");
    end

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   work_q;
    logic            mode_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic            busy_q;

    logic [KW-1:0]   chunk_in;
    logic [KW-1:0]   chunk_out;
    logic [DW-1:0]   work_nxt;
    logic            last_chunk;

    // Pick the chunk addressed by the counter.
    always_comb begin
        chunk_in = '0;
        for (int unsigned k = 0; k < C; k++) begin
            if (cnt_q == CW'(k)) begin
                chunk_in = work_q[k*KW +: KW];
            end
        end
    end

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        rijndael_sbox_dual u_sbox (
            .x_i   (chunk_in[8*g +: 8]),
            .inv_i (mode_q),
            .y_o   (chunk_out[8*g +: 8])
        );
    end

    // Working state with the current chunk replaced by its substitution.
    always_comb begin
        work_nxt = work_q;
        for (int unsigned k = 0; k < C; k++) begin
            if (cnt_q == CW'(k)) begin
                work_nxt[k*KW +: KW] = chunk_out;
            end
        end
    end

    assign last_chunk = (cnt_q == CW'(C - 1));

    // Control FSM plus working, mode and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid_i) begin
                        work_q  <= bus.in_data_i;
                        mode_q  <= bus.in_inv_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work_q <= work_nxt;
                    if (last_chunk) begin
                        cnt_q       <= '0;
                        out_data_q  <= work_nxt;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid_i) begin
                            work_q  <= bus.in_data_i;
                            mode_q  <= bus.in_inv_i;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Ready is combinational so a drained result can be replaced in the same cycle.
    assign bus.in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready_i);
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_rijndael_subbytes_engine.sv
// Self-checking bench: directed vectors, corner sequences, parameter sweep and random scoreboard.
module tb_rijndael_subbytes_engine;
    localparam int NCFG  = 5;
    localparam int NRAND = 3000;
    localparam int NSWP  = 40;

    function automatic int unsigned cfg_lanes(input int g);
        case (g)
            0: return 16;
            1: return 16;
            2: return 32;
            3: return 24;
            default: return 20;
        endcase
    endfunction

    function automatic int unsigned cfg_sbox(input int g);
        case (g)
            0: return 4;
            1: return 16;
            2: return 1;
            3: return 8;
            default: return 4;
        endcase
    endfunction

    logic clk;
    logic rst_n;

    logic         in_valid  [NCFG];
    logic         in_inv    [NCFG];
    logic [255:0] in_data   [NCFG];
    logic         out_ready [NCFG];
    logic         in_ready  [NCFG];
    logic         out_valid [NCFG];
    logic         busy      [NCFG];
    logic [255:0] out_data  [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned L = cfg_lanes(g);
        localparam int unsigned S = cfg_sbox(g);
        rijndael_subbytes_engine_if #(.NUM_LANES(L)) bus ();
        assign bus.in_valid_i  = in_valid[g];
        assign bus.in_inv_i    = in_inv[g];
        assign bus.in_data_i   = in_data[g][8*L-1:0];
        assign bus.out_ready_i = out_ready[g];
        assign in_ready[g]     = bus.in_ready_o;
        assign out_valid[g]    = bus.out_valid_o;
        assign busy[g]         = bus.busy_o;
        assign out_data[g]     = 256'(bus.out_data_o);
        rijndael_subbytes_engine #(.NUM_LANES(L), .NUM_SBOX(S)) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference S-boxes derived from GF(2^8) inversion and the affine map.
    logic [7:0] sbox_f [256];
    logic [7:0] sbox_i [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int v = 0; v < 256; v++) begin
            b = 8'h00;
            for (int w = 1; w < 256; w++) begin
                if (gmul(8'(v), 8'(w)) == 8'h01) b = 8'(w);
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox_f[v] = s;
            sbox_i[s] = 8'(v);
        end
    endtask

    function automatic logic [255:0] ref_sub(input logic [255:0] d, input logic inv, input int unsigned lanes);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < int'(lanes); k++) begin
            r[8*k +: 8] = inv ? sbox_i[d[8*k +: 8]] : sbox_f[d[8*k +: 8]];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_state(input int unsigned lanes);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < int'(lanes); k++) r[8*k +: 8] = 8'($urandom);
        return r;
    endfunction

    // Wait (from a negedge) for out_valid, scrambling unused inputs; counts edges.
    task automatic wait_result(input int g, output int lat);
        lat = 0;
        while (!out_valid[g] && lat < 100) begin
            in_data[g] = rand_state(cfg_lanes(g));
            in_inv[g]  = 1'($urandom);
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[g] = 1'b0;
    endtask

    // One full transaction from IDLE; returns result and latency.
    task automatic run_txn(input int g, input logic [255:0] d, input logic inv,
                           output logic [255:0] res, output int lat);
        in_data[g] = d; in_inv[g] = inv; in_valid[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid[g] = 1'b0;
        wait_result(g, lat);
        res = out_data[g];
        ack(g);
    endtask

    typedef struct {
        logic [255:0] data;
        logic         inv;
        logic [255:0] exp;
    } vec_t;

    vec_t         vecs [6];
    logic [255:0] res, a, b, back;
    int           lat;
    int           acc, del, cyc;
    logic [255:0] exp_q [$];

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            in_valid[g] = 1'b0; in_inv[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
        end
        build_tables();

        vecs[0] = '{256'(128'h00112233445566778899aabbccddeeff), 1'b0, 256'(128'h638293c31bfc33f5c4eeacea4bc12816)};
        vecs[1] = '{256'(128'h638293c31bfc33f5c4eeacea4bc12816), 1'b1, 256'(128'h00112233445566778899aabbccddeeff)};
        vecs[2] = '{256'({16{8'h00}}), 1'b0, 256'({16{8'h63}})};
        vecs[3] = '{256'({16{8'h00}}), 1'b1, 256'({16{8'h52}})};
        vecs[4] = '{256'({16{8'h01}}), 1'b0, 256'({16{8'h7c}})};
        vecs[5] = '{256'({16{8'h53}}), 1'b0, 256'({16{8'hed}})};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 256'(out_valid[0]), 256'(0));
        check("rst_out_data", out_data[0], '0);
        check("rst_busy", 256'(busy[0]), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready[0]), 256'(1));

        // Directed vectors on the default configuration.
        for (int i = 0; i < 6; i++) begin
            run_txn(0, vecs[i].data, vecs[i].inv, res, lat);
            check("vec_latency", 256'(lat), 256'(4));
            check("vec_data", res, vecs[i].exp);
            if (i == 1) begin
                back = res;
                check("inv_lane0_16", 256'(back[7:0]), 256'(8'hff));
                check("inv_lane15_63", 256'(back[127:120]), 256'(8'h00));
            end
        end

        // Stall in DONE, then same-cycle drain and accept.
        a = rand_state(16); b = rand_state(16);
        in_data[0] = a; in_inv[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        wait_result(0, lat);
        check("stall_latency", 256'(lat), 256'(4));
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 256'(out_valid[0]), 256'(1));
            check("stall_data", out_data[0], ref_sub(a, 1'b0, 16));
            check("stall_in_ready", 256'(in_ready[0]), 256'(0));
            in_data[0] = rand_state(16);
            @(posedge clk); @(negedge clk);
        end
        in_data[0] = b; in_inv[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        check("overlap_in_ready", 256'(in_ready[0]), 256'(1));
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        check("overlap_valid_drop", 256'(out_valid[0]), 256'(0));
        check("overlap_busy", 256'(busy[0]), 256'(1));
        wait_result(0, lat);
        check("overlap_latency", 256'(lat), 256'(4));
        check("overlap_data", out_data[0], ref_sub(b, 1'b1, 16));
        ack(0);

        // Asynchronous reset while chunk 2 is pending.
        in_data[0] = rand_state(16); in_inv[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 256'(out_valid[0]), 256'(0));
        check("midrst_out_data", out_data[0], '0);
        check("midrst_busy", 256'(busy[0]), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 256'(in_ready[0]), 256'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            check("midrst_no_partial", 256'(out_valid[0]), 256'(0));
        end
        a = rand_state(16);
        run_txn(0, a, 1'b1, res, lat);
        check("midrst_next_latency", 256'(lat), 256'(4));
        check("midrst_next_data", res, ref_sub(a, 1'b1, 16));

        // Parameter sweep: latency, reference match and round trip.
        for (int g = 0; g < NCFG; g++) begin
            for (int i = 0; i < NSWP; i++) begin
                logic inv;
                a   = rand_state(cfg_lanes(g));
                inv = 1'($urandom);
                run_txn(g, a, inv, res, lat);
                check("swp_latency", 256'(lat), 256'(cfg_lanes(g) / cfg_sbox(g)));
                check("swp_data", res, ref_sub(a, inv, cfg_lanes(g)));
                run_txn(g, res, ~inv, back, lat);
                check("swp_roundtrip", back, a);
            end
        end

        // Random handshake scoreboard on the default configuration.
        acc = 0; del = 0; cyc = 0;
        while (del < NRAND && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready[0] = ($urandom_range(0, 3) != 0);
            if (acc < NRAND) begin
                in_valid[0] = ($urandom_range(0, 3) != 0);
                in_data[0]  = rand_state(16);
                in_inv[0]   = 1'($urandom);
            end else begin
                in_valid[0] = 1'b0;
            end
            #1;
            if (in_valid[0] && in_ready[0]) begin
                exp_q.push_back(ref_sub(in_data[0], in_inv[0], 16));
                acc++;
            end
            if (out_valid[0] && out_ready[0]) begin
                check("sb_pending", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) check("sb_data", out_data[0], exp_q.pop_front());
                del++;
            end
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        check("sb_delivered", 256'(del), 256'(NRAND));
        check("sb_leftover", 256'(exp_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
